mips_alu: RTL and testbench



---
 rtl/mips_alu.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS execute-stage ALU with single-cycle ops and a 32-iteration restoring-division MOD.
// Optional build macro ALU_SIGNED_MOD_EN selects a signed (C-style) remainder; by default MOD is unsigned.

module mips_alu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic        Z,
  output logic        V,
  output logic        C,
  output logic [31:0] Result,
  output logic        We
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOR = 3'd5,
    OP_SLT = 3'd6,
    OP_MOD = 3'd7
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Launch register: operands and opcode of the last launched operation.
  logic [31:0] a_l_q, a_l_d;
  logic [31:0] b_l_q, b_l_d;
  logic [2:0]  op_l_q, op_l_d;

  logic [31:0] result_q, result_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        c_q, c_d;
  logic        we_q, we_d;

  // Divider working set: partial remainder, dividend being shifted out, divisor, iteration count.
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
`ifdef ALU_SIGNED_MOD_EN
  logic        neg_q, neg_d;
`endif

  alu_op_e     op;
  logic        launch;
  logic        last_iter;

  assign op        = alu_op_e'(ALUOp);
  assign launch    = (state_q == S_IDLE) && ({A, B, ALUOp} != {a_l_q, b_l_q, op_l_q});
  assign last_iter = (cnt_q == 5'd31);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] alu_res;
  logic        alu_v;
  logic        alu_c;

  // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    is_sub  = (op == OP_SUB);
    b_eff   = is_sub ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {32'd0, is_sub};
    ovf     = (A[31] == b_eff[31]) && (sum[31] != A[31]);
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[31:0];
        alu_v   = ovf;
        alu_c   = sum[32];
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLT:  alu_res = {31'd0, $signed(A) < $signed(B)};
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring-division step and operand conditioning
  // ---------------------------------------------------------------------------
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] mod_res;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    trial    = {rem_q, quo_q[31]};
    ge       = (trial >= {1'b0, dvs_q});
    // After a successful subtract the remainder is below the divisor, so 32 bits always suffice.
    rem_step = ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
`ifdef ALU_SIGNED_MOD_EN
    a_mag    = A[31] ? (~A + 32'd1) : A;
    b_mag    = B[31] ? (~B + 32'd1) : B;
    mod_res  = neg_q ? (~rem_step + 32'd1) : rem_step;
`else
    a_mag    = A;
    b_mag    = B;
    mod_res  = rem_step;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch && (op == OP_MOD)) state_d = S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    a_l_d    = a_l_q;
    b_l_d    = b_l_q;
    op_l_d   = op_l_q;
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    we_d     = 1'b0;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
`ifdef ALU_SIGNED_MOD_EN
    neg_d    = neg_q;
`endif

    if (launch) begin
      a_l_d  = A;
      b_l_d  = B;
      op_l_d = ALUOp;
      if (op == OP_MOD) begin
        rem_d = '0;
        quo_d = a_mag;
        dvs_d = b_mag;
        cnt_d = '0;
`ifdef ALU_SIGNED_MOD_EN
        neg_d = A[31];
`endif
      end else begin
        result_d = alu_res;
        z_d      = (alu_res == 32'd0);
        v_d      = alu_v;
        c_d      = alu_c;
        we_d     = 1'b1;
      end
    end

    if (state_q == S_BUSY) begin
      rem_d = rem_step;
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
      // A zero divisor lets every step succeed, so the remainder rebuilds A exactly.
      if (last_iter) begin
        result_d = mod_res;
        z_d      = (mod_res == 32'd0);
        v_d      = (dvs_q == 32'd0);
        c_d      = 1'b0;
        we_d     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      a_l_q    <= '0;
      b_l_q    <= '0;
      op_l_q   <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      we_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_SIGNED_MOD_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_l_q    <= a_l_d;
      b_l_q    <= b_l_d;
      op_l_q   <= op_l_d;
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
      we_q     <= we_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SIGNED_MOD_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign Result = result_q;
  assign Z      = z_q;
  assign V      = v_q;
  assign C      = c_q;
  assign We     = we_q;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed test-plan checks plus randomized stimulus against an arithmetic reference model.
// Honors ALU_SIGNED_MOD_EN the same way as the design.

module tb_mips_alu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic        Z;
  logic        V;
  logic        C;
  logic [31:0] Result;
  logic        We;

  always #5 Clk = ~Clk;

  mips_alu dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .A      (A),
    .B      (B),
    .ALUOp  (ALUOp),
    .Z      (Z),
    .V      (V),
    .C      (C),
    .Result (Result),
    .We     (We)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: results straight from the arithmetic definitions.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] res;
    logic        v;
    logic        c;
  } ref_t;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  function automatic ref_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    ref_t            r;
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          m;
    r = '0;
    case (op)
      3'd0: begin
        r.res = a + b;
        r.c   = (ua + ub) > 64'hFFFF_FFFF;
        r.v   = (sa + sb > MAX_S) || (sa + sb < MIN_S);
      end
      3'd1: begin
        r.res = a - b;
        r.c   = (a >= b);
        r.v   = (sa - sb > MAX_S) || (sa - sb < MIN_S);
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.res = ~(a | b);
      3'd6: r.res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        if (b == 32'd0) begin
          r.res = a;
          r.v   = 1'b1;
        end else begin
`ifdef ALU_SIGNED_MOD_EN
          m     = sa % sb;
`else
          m     = longint'(ua % ub);
`endif
          r.res = m[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Expected outputs, updated on each rising edge from the launch/latency rules.
  logic [66:0] last_launch;
  int          busy_left;
  ref_t        pend;
  ref_t        now_r;
  logic [31:0] e_res;
  logic        e_z, e_v, e_c, e_we;

  initial begin
    last_launch = '0;
    busy_left   = 0;
    pend        = '0;
    e_res = '0; e_z = 1'b0; e_v = 1'b0; e_c = 1'b0; e_we = 1'b0;
  end

  always @(posedge Clk) begin
    if (Reset) begin
      last_launch = '0;
      busy_left   = 0;
      e_res = '0; e_z = 1'b0; e_v = 1'b0; e_c = 1'b0; e_we = 1'b0;
    end else begin
      e_we = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          e_res = pend.res; e_z = (pend.res == 32'd0); e_v = pend.v; e_c = pend.c; e_we = 1'b1;
        end
      end else if ({A, B, ALUOp} != last_launch) begin
        last_launch = {A, B, ALUOp};
        now_r       = ref_op(A, B, ALUOp);
        if (ALUOp == 3'd7) begin
          pend      = now_r;
          busy_left = 32;
        end else begin
          e_res = now_r.res; e_z = (now_r.res == 32'd0); e_v = now_r.v; e_c = now_r.c; e_we = 1'b1;
        end
      end
    end
    #1;
    check("Result", Result, e_res);
    check("Z", 32'(Z), 32'(e_z));
    check("V", 32'(V), 32'(e_v));
    check("C", 32'(C), 32'(e_c));
    check("We", 32'(We), 32'(e_we));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Applies inputs at the falling edge and returns just after the following rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge Clk);
    A = a; B = b; ALUOp = op;
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_mod();
    repeat (32) @(posedge Clk);
    #2;
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic z, input logic v,
                           input logic c, input logic we);
    check({tag, ".Result"}, Result, r);
    check({tag, ".Z"}, 32'(Z), 32'(z));
    check({tag, ".V"}, 32'(V), 32'(v));
    check({tag, ".C"}, 32'(C), 32'(c));
    check({tag, ".We"}, 32'(We), 32'(we));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int we_seen;

  initial begin
    Reset = 1'b1; A = '0; B = '0; ALUOp = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_out("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Remainder of 16 by 5 completes 32 edges after launch.
    drive(32'd16, 32'd5, 3'd7);
    check("mod16_busy_we", 32'(We), 32'd0);
    wait_mod();
    check_out("mod16", 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Launch on the edge right after completion.
    drive(32'h7FFF_FFFF, 32'd1, 3'd0);
    check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge Clk); #2;
    check("add_ovf_we_drop", 32'(We), 32'd0);

    drive(32'hFFFF_FFFF, 32'd1, 3'd0);
    check_out("add_carry", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(32'd5, 32'd5, 3'd1);
    check_out("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(32'hFFFF_FFFF, 32'd5, 3'd6);
    check_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(32'd123, 32'd0, 3'd7);
    wait_mod();
    check_out("mod_div0", 32'd123, 1'b0, 1'b1, 1'b0, 1'b1);

    drive(32'hFFFF_FFF0, 32'd5, 3'd7);
    wait_mod();
`ifdef ALU_SIGNED_MOD_EN
    check_out("mod_neg", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    check_out("mod_neg", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Input change during a busy remainder operation is deferred until after completion.
    drive(32'd100, 32'd7, 3'd7);
    @(negedge Clk);
    A = 32'd1; B = 32'd2; ALUOp = 3'd0;
    repeat (32) @(posedge Clk);
    #2;
    check_out("mod_busy_first", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk); #2;
    check_out("add_after_mod", 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge Clk); #2;
    check("unchanged_no_relaunch", 32'(We), 32'd0);

    // Reset ten cycles into a remainder operation aborts it with no completion pulse.
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
    check_out("add_pre_reset", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(32'd1000, 32'd9, 3'd7);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1; A = '0; B = '0; ALUOp = '0;
    #1;
    check_out("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #2;
      if (We) we_seen++;
    end
    check("no_launch_after_reset", 32'(we_seen), 32'd0);
    check("result_after_reset", Result, 32'd0);

    // Randomized traffic; held inputs and busy-time changes exercise the launch rule.
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      if ($urandom_range(0, 3) != 0) begin
        A     = pick();
        B     = pick();
        ALUOp = 3'($urandom_range(0, 7));
      end
    end
    repeat (40) @(posedge Clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
